// File: rtl/fdc_pkg.sv
// Types and constants shared by the FDC self-test stimulus blocks and the FDC core.
package fdc_pkg;

  // Width of the frequency control word; must equal the FDC core result width.
  localparam int unsigned FCW_W         = 5;
  localparam int unsigned ACC_W_DEF     = 16;
  localparam int unsigned BASE_INC_DEF  = 256;
  localparam int unsigned INC_SHIFT_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLEW = 2'd2
  } nco_state_e;

endpackage

// File: rtl/fdc_stim_nco_if.sv
// FCW load handshake between a requester and the stimulus NCO.
interface fdc_stim_nco_if;
  import fdc_pkg::*;

  logic [FCW_W-1:0] fcw_in;
  logic             fcw_load;
  logic             slew_en;
  logic             fcw_ack;
  logic             busy;
  logic [FCW_W-1:0] fcw_cur;

  modport master (
    output fcw_in, fcw_load, slew_en,
    input  fcw_ack, busy, fcw_cur
  );

  modport slave (
    input  fcw_in, fcw_load, slew_en,
    output fcw_ack, busy, fcw_cur
  );

endinterface

// File: rtl/fdc_ref_div.sv
// Reference divider: 50% duty square wave of period REF_DIV clocks while en is high.
module fdc_ref_div #(
  parameter int unsigned REF_DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic ref_out
);

  localparam int unsigned HALF = REF_DIV / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ref_out <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      ref_out <= 1'b0;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt     <= '0;
      ref_out <= ~ref_out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fdc_stim_nco.sv
// FCW-controlled square-wave source (phase accumulator) plus divided reference,
// used to stimulate the FDC for on-chip self-test.
module fdc_stim_nco
  import fdc_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned BASE_INC  = BASE_INC_DEF,
  parameter int unsigned INC_SHIFT = INC_SHIFT_DEF,
  parameter int unsigned REF_DIV   = 64,
  parameter int unsigned SLEW_DIV  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  fdc_stim_nco_if.slave  bus,
  output logic           vco_out,
  output logic           ref_out
);

  localparam int unsigned SC_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  nco_state_e       state, state_n;
  logic [FCW_W-1:0] fcw_cur, fcw_cur_n, target, target_n, fcw_step;
  logic [SC_W-1:0]  slew_cnt, slew_cnt_n;
  logic             ack_pend, ack_pend_n, fcw_ack;
  logic [ACC_W-1:0] acc, inc;
  logic             run;

  assign run = ena && (state != ST_IDLE);
  assign inc = ACC_W'(BASE_INC) + (ACC_W'(fcw_cur) << INC_SHIFT);

  assign bus.fcw_cur = fcw_cur;
  assign bus.busy    = (state == ST_SLEW);
  assign bus.fcw_ack = fcw_ack;

  always_comb begin
    fcw_step = (target > fcw_cur) ? fcw_cur + FCW_W'(1) : fcw_cur - FCW_W'(1);
  end

  always_comb begin
    state_n    = state;
    fcw_cur_n  = fcw_cur;
    target_n   = target;
    slew_cnt_n = slew_cnt;
    ack_pend_n = 1'b0;
    if (!ena) begin
      // Disable wins over everything; a coincident load is applied as in IDLE.
      state_n = ST_IDLE;
      if (bus.fcw_load) begin
        fcw_cur_n  = bus.fcw_in;
        ack_pend_n = 1'b1;
      end
      target_n = fcw_cur_n;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_RUN;
          if (bus.fcw_load) begin
            fcw_cur_n  = bus.fcw_in;
            target_n   = bus.fcw_in;
            ack_pend_n = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.fcw_load) begin
            ack_pend_n = 1'b1;
            target_n   = bus.fcw_in;
            if (!bus.slew_en || (bus.fcw_in == fcw_cur)) begin
              fcw_cur_n = bus.fcw_in;
            end else begin
              slew_cnt_n = '0;
              state_n    = ST_SLEW;
            end
          end
        end
        ST_SLEW: begin
          if (slew_cnt == SC_W'(SLEW_DIV - 1)) begin
            slew_cnt_n = '0;
            fcw_cur_n  = fcw_step;
            if (fcw_step == target) state_n = ST_RUN;
          end else begin
            slew_cnt_n = slew_cnt + SC_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fcw_cur  <= '0;
      target   <= '0;
      slew_cnt <= '0;
      ack_pend <= 1'b0;
      fcw_ack  <= 1'b0;
    end else begin
      state    <= state_n;
      fcw_cur  <= fcw_cur_n;
      target   <= target_n;
      slew_cnt <= slew_cnt_n;
      ack_pend <= ack_pend_n;
      fcw_ack  <= ack_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      vco_out <= 1'b0;
    end else if (!run) begin
      acc     <= '0;
      vco_out <= 1'b0;
    end else begin
      acc     <= acc + inc;
      vco_out <= acc[ACC_W-1];
    end
  end

  fdc_ref_div #(
    .REF_DIV (REF_DIV)
  ) u_ref_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .ref_out (ref_out)
  );

endmodule

// File: tb/tb_fdc_stim_nco.sv
// Directed self-checking bench for fdc_stim_nco with hand-computed expectations.
module tb_fdc_stim_nco;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic vco_out;
  logic ref_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fdc_stim_nco_if u_if ();

  fdc_stim_nco dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bus     (u_if.slave),
    .vco_out (vco_out),
    .ref_out (ref_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Instant (or slewed) load, held for exactly one sampling edge.
  task automatic load(input int unsigned fcw, input bit slew);
    u_if.fcw_in   = 5'(fcw);
    u_if.slew_en  = slew;
    u_if.fcw_load = 1'b1;
    tick();
    u_if.fcw_load = 1'b0;
    tick(3);
  endtask

  // Period and high time (in clocks) of vco_out (sel=0) or ref_out (sel=1).
  task automatic measure(input bit sel, output int unsigned period, output int unsigned high);
    bit prev, cur, found;
    period = 0;
    high   = 0;
    found  = 1'b0;
    prev   = sel ? ref_out : vco_out;
    for (int unsigned i = 0; i < 2000 && !found; i++) begin
      tick();
      cur   = sel ? ref_out : vco_out;
      found = !prev && cur;
      prev  = cur;
    end
    if (!found) begin
      check("rise_timeout", 0, 1);
      return;
    end
    high  = 1;
    found = 1'b0;
    for (int unsigned i = 0; i < 2000 && !found; i++) begin
      tick();
      period++;
      cur = sel ? ref_out : vco_out;
      if (!prev && cur) found = 1'b1;
      else if (cur) high++;
      prev = cur;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned per, hi, cnt_a, cnt_b, cnt_c;
    bit prev;

    rst_n = 1'b0;
    ena   = 1'b0;
    u_if.fcw_in   = '0;
    u_if.fcw_load = 1'b0;
    u_if.slew_en  = 1'b0;

    // 1: reset, then idle with ena=0
    tick(3);
    check("rst_vco", vco_out, 0);
    check("rst_ref", ref_out, 0);
    check("rst_ack", u_if.fcw_ack, 0);
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      tick();
      if (ref_out) cnt_a++;
      if (vco_out) cnt_b++;
      if (u_if.busy || u_if.fcw_ack || (u_if.fcw_cur != 0)) cnt_c++;
    end
    check("idle_ref_high", cnt_a, 0);
    check("idle_vco_high", cnt_b, 0);
    check("idle_misc", cnt_c, 0);

    // 2: run at fcw 0
    ena = 1'b1;
    measure(1'b0, per, hi);
    check("vco0_period", per, 256);
    check("vco0_high", hi, 128);
    measure(1'b1, per, hi);
    check("ref_period", per, 64);
    check("ref_high", hi, 32);

    // 3: instant load of 31
    u_if.fcw_in   = 5'd31;
    u_if.slew_en  = 1'b0;
    u_if.fcw_load = 1'b1;
    tick();
    u_if.fcw_load = 1'b0;
    check("l31_ack_early", u_if.fcw_ack, 0);
    check("l31_cur", u_if.fcw_cur, 31);
    tick();
    check("l31_ack", u_if.fcw_ack, 1);
    tick();
    check("l31_ack_drop", u_if.fcw_ack, 0);
    tick(4);
    cnt_a = 0;
    prev  = vco_out;
    for (int unsigned i = 0; i < 65536; i++) begin
      tick();
      if (!prev && vco_out) cnt_a++;
      prev = vco_out;
    end
    check("l31_rises", cnt_a, 2240);

    // 4: slew 0 -> 4 with a refused load of 9
    load(0, 1'b0);
    check("pre4_cur", u_if.fcw_cur, 0);
    u_if.fcw_in   = 5'd4;
    u_if.slew_en  = 1'b1;
    u_if.fcw_load = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int unsigned k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) u_if.fcw_load = 1'b0;
      if (k == 10) begin
        u_if.fcw_in   = 5'd9;
        u_if.fcw_load = 1'b1;
      end
      if (k == 11) u_if.fcw_load = 1'b0;
      if (u_if.busy) cnt_a++;
      if (k >= 3 && u_if.fcw_ack) cnt_b++;
      if (k == 2)  check("s4_ack", u_if.fcw_ack, 1);
      if (k == 8)  check("s4_cur_k8", u_if.fcw_cur, 0);
      if (k == 9)  check("s4_cur_k9", u_if.fcw_cur, 1);
      if (k == 17) check("s4_cur_k17", u_if.fcw_cur, 2);
      if (k == 25) check("s4_cur_k25", u_if.fcw_cur, 3);
      if (k == 32) check("s4_busy_k32", u_if.busy, 1);
      if (k == 33) check("s4_cur_k33", u_if.fcw_cur, 4);
      if (k == 33) check("s4_busy_k33", u_if.busy, 0);
    end
    check("s4_busy_cycles", cnt_a, 32);
    check("s4_refused_ack", cnt_b, 0);
    check("s4_final_cur", u_if.fcw_cur, 4);

    // 5: slew 5 -> 3, abort after the first step
    load(5, 1'b0);
    check("pre5_cur", u_if.fcw_cur, 5);
    u_if.fcw_in   = 5'd3;
    u_if.slew_en  = 1'b1;
    u_if.fcw_load = 1'b1;
    for (int unsigned k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) u_if.fcw_load = 1'b0;
    end
    check("s5_step_cur", u_if.fcw_cur, 4);
    check("s5_step_busy", u_if.busy, 1);
    ena = 1'b0;
    tick();
    check("s5_off_busy", u_if.busy, 0);
    check("s5_off_vco", vco_out, 0);
    check("s5_off_ref", ref_out, 0);
    check("s5_off_cur", u_if.fcw_cur, 4);
    ena = 1'b1;
    tick(20);
    check("s5_on_cur", u_if.fcw_cur, 4);
    check("s5_on_busy", u_if.busy, 0);
    measure(1'b0, per, hi);
    check("vco4_period", per, 128);

    // 6: asynchronous reset mid-slew
    load(4, 1'b0);
    u_if.fcw_in   = 5'd10;
    u_if.slew_en  = 1'b1;
    u_if.fcw_load = 1'b1;
    tick();
    u_if.fcw_load = 1'b0;
    tick(11);
    check("s6_busy", u_if.busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_cur", u_if.fcw_cur, 0);
    check("s6_rst_busy", u_if.busy, 0);
    check("s6_rst_vco", vco_out, 0);
    check("s6_rst_ref", ref_out, 0);
    #10;
    rst_n = 1'b1;
    cnt_a = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      if (u_if.fcw_ack) cnt_a++;
    end
    check("s6_spurious_ack", cnt_a, 0);
    check("s6_post_cur", u_if.fcw_cur, 0);
    check("s6_post_busy", u_if.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
